// File: rtl/lpm_memory_arbiter.sv
// Two-client round-robin arbiter in front of a single-outstanding LPM memory.
// Optional performance counters are enabled by defining LPM_ARB_PERF_EN.
module lpm_memory_arbiter #(
  parameter int unsigned DATA_WIDTH = 704
) (
`ifdef LPM_ARB_PERF_EN
  output logic [31:0]           c0_grant_count,
  output logic [31:0]           c1_grant_count,
  output logic [31:0]           contend_count,
`endif
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  c0_req__ENA,
  input  logic [DATA_WIDTH-1:0] c0_v,
  output logic                  c0_req__RDY,
  input  logic                  c0_resAccept__ENA,
  output logic                  c0_resAccept__RDY,
  output logic [DATA_WIDTH-1:0] c0_resValue,
  output logic                  c0_resValue__RDY,
  input  logic                  c1_req__ENA,
  input  logic [DATA_WIDTH-1:0] c1_v,
  output logic                  c1_req__RDY,
  input  logic                  c1_resAccept__ENA,
  output logic                  c1_resAccept__RDY,
  output logic [DATA_WIDTH-1:0] c1_resValue,
  output logic                  c1_resValue__RDY,
  output logic                  mem_req__ENA,
  output logic [DATA_WIDTH-1:0] mem_v,
  input  logic                  mem_req__RDY,
  output logic                  mem_resAccept__ENA,
  input  logic                  mem_resAccept__RDY,
  input  logic [DATA_WIDTH-1:0] mem_resValue,
  input  logic                  mem_resValue__RDY
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } st_t;

  st_t  st_q, st_d;
  logic owner_q, owner_d;
  logic prio_q, prio_d;
  logic grant0, grant1, accept;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      st_q    <= ST_IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
    end
  end

  // Handshake outputs are gated by nRST so they drop the moment reset asserts.
  always_comb begin
    st_d               = st_q;
    owner_d            = owner_q;
    prio_d             = prio_q;
    grant0             = 1'b0;
    grant1             = 1'b0;
    accept             = 1'b0;
    c0_req__RDY        = 1'b0;
    c1_req__RDY        = 1'b0;
    c0_resAccept__RDY  = 1'b0;
    c1_resAccept__RDY  = 1'b0;
    c0_resValue__RDY   = 1'b0;
    c1_resValue__RDY   = 1'b0;
    mem_req__ENA       = 1'b0;
    mem_resAccept__ENA = 1'b0;
    if (nRST) begin
      unique case (st_q)
        ST_IDLE: begin
          c0_req__RDY  = mem_req__RDY && (!prio_q || !c1_req__ENA);
          c1_req__RDY  = mem_req__RDY && ( prio_q || !c0_req__ENA);
          grant0       = c0_req__ENA && c0_req__RDY;
          grant1       = c1_req__ENA && c1_req__RDY;
          mem_req__ENA = grant0 || grant1;
          if (grant0 || grant1) begin
            st_d    = ST_BUSY;
            owner_d = grant1;
          end
        end
        ST_BUSY: begin
          c0_resValue__RDY  = mem_resValue__RDY  && !owner_q;
          c1_resValue__RDY  = mem_resValue__RDY  &&  owner_q;
          c0_resAccept__RDY = mem_resAccept__RDY && !owner_q;
          c1_resAccept__RDY = mem_resAccept__RDY &&  owner_q;
          accept = owner_q ? (c1_resAccept__ENA && c1_resAccept__RDY)
                           : (c0_resAccept__ENA && c0_resAccept__RDY);
          mem_resAccept__ENA = accept;
          if (accept) begin
            st_d   = ST_IDLE;
            prio_d = ~owner_q;
          end
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  assign mem_v       = grant1 ? c1_v : c0_v;
  assign c0_resValue = mem_resValue;
  assign c1_resValue = mem_resValue;

`ifdef LPM_ARB_PERF_EN
  logic contend;
  assign contend = (st_q == ST_IDLE) && mem_req__RDY && c0_req__ENA && c1_req__ENA;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      c0_grant_count <= '0;
      c1_grant_count <= '0;
      contend_count  <= '0;
    end else begin
      if (grant0)  c0_grant_count <= c0_grant_count + 32'd1;
      if (grant1)  c1_grant_count <= c1_grant_count + 32'd1;
      if (contend) contend_count  <= contend_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lpm_memory_arbiter.sv
// Directed bench for lpm_memory_arbiter: grants, ownership steering, fairness, reset.
// Counter checks are compiled in when LPM_ARB_PERF_EN is defined.
module tb_lpm_memory_arbiter;
  localparam int unsigned DW = 704;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          c0_req__ENA, c0_req__RDY, c0_resAccept__ENA, c0_resAccept__RDY, c0_resValue__RDY;
  logic          c1_req__ENA, c1_req__RDY, c1_resAccept__ENA, c1_resAccept__RDY, c1_resValue__RDY;
  logic [DW-1:0] c0_v, c1_v, c0_resValue, c1_resValue, mem_v, mem_resValue;
  logic          mem_req__ENA, mem_req__RDY, mem_resAccept__ENA, mem_resAccept__RDY, mem_resValue__RDY;
`ifdef LPM_ARB_PERF_EN
  logic [31:0]   c0_grant_count, c1_grant_count, contend_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  lpm_memory_arbiter #(.DATA_WIDTH(DW)) dut (
`ifdef LPM_ARB_PERF_EN
    .c0_grant_count    (c0_grant_count),
    .c1_grant_count    (c1_grant_count),
    .contend_count     (contend_count),
`endif
    .CLK               (CLK),
    .nRST              (nRST),
    .c0_req__ENA       (c0_req__ENA),
    .c0_v              (c0_v),
    .c0_req__RDY       (c0_req__RDY),
    .c0_resAccept__ENA (c0_resAccept__ENA),
    .c0_resAccept__RDY (c0_resAccept__RDY),
    .c0_resValue       (c0_resValue),
    .c0_resValue__RDY  (c0_resValue__RDY),
    .c1_req__ENA       (c1_req__ENA),
    .c1_v              (c1_v),
    .c1_req__RDY       (c1_req__RDY),
    .c1_resAccept__ENA (c1_resAccept__ENA),
    .c1_resAccept__RDY (c1_resAccept__RDY),
    .c1_resValue       (c1_resValue),
    .c1_resValue__RDY  (c1_resValue__RDY),
    .mem_req__ENA      (mem_req__ENA),
    .mem_v             (mem_v),
    .mem_req__RDY      (mem_req__RDY),
    .mem_resAccept__ENA(mem_resAccept__ENA),
    .mem_resAccept__RDY(mem_resAccept__RDY),
    .mem_resValue      (mem_resValue),
    .mem_resValue__RDY (mem_resValue__RDY)
  );

  always #5 CLK = ~CLK;

  // Bit order: c0_req_RDY c1_req_RDY mem_req_ENA mem_resAcc_ENA c0_resAcc_RDY c0_resVal_RDY c1_resAcc_RDY c1_resVal_RDY
  function automatic logic [7:0] ctl();
    return {c0_req__RDY, c1_req__RDY, mem_req__ENA, mem_resAccept__ENA,
            c0_resAccept__RDY, c0_resValue__RDY, c1_resAccept__RDY, c1_resValue__RDY};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic req(input string tag, input logic e0, input logic e1,
                     input logic [7:0] exp_ctl, input logic [DW-1:0] exp_v);
    c0_req__ENA = e0;
    c1_req__ENA = e1;
    #1;
    chk({tag, "_ctl"}, ctl(), exp_ctl);
    chk({tag, "_memv"}, mem_v, exp_v);
    tick();
    c0_req__ENA  = 1'b0;
    c1_req__ENA  = 1'b0;
    mem_req__RDY = 1'b0;
    #1;
    chk({tag, "_busy"}, ctl(), 8'b0000_0000);
  endtask

  task automatic serve(input string tag, input logic own, input logic [DW-1:0] res);
    mem_resValue       = res;
    mem_resValue__RDY  = 1'b1;
    mem_resAccept__RDY = 1'b1;
    #1;
    chk({tag, "_resp"}, ctl(), own ? 8'b0000_0011 : 8'b0000_1100);
    chk({tag, "_val0"}, c0_resValue, res);
    chk({tag, "_val1"}, c1_resValue, res);
    if (own) c1_resAccept__ENA = 1'b1;
    else     c0_resAccept__ENA = 1'b1;
    #1;
    chk({tag, "_acc"}, ctl(), own ? 8'b0001_0011 : 8'b0001_1100);
    tick();
    c0_resAccept__ENA  = 1'b0;
    c1_resAccept__ENA  = 1'b0;
    mem_resValue__RDY  = 1'b0;
    mem_resAccept__RDY = 1'b0;
    mem_req__RDY       = 1'b1;
  endtask

  initial begin
    c0_v = DW'(32'hA5);
    c1_v = DW'(32'h3C);
    mem_resValue = '0;
    c0_resAccept__ENA = 1'b0;
    c1_resAccept__ENA = 1'b0;
    // Reset with every input asserted: handshake outputs must be low
    nRST = 1'b0;
    mem_req__RDY = 1'b1; mem_resValue__RDY = 1'b1; mem_resAccept__RDY = 1'b1;
    c0_req__ENA = 1'b1; c1_req__ENA = 1'b1;
    #2;
    chk("reset_outs", ctl(), 8'b0000_0000);
    tick(); tick();
    c0_req__ENA = 1'b0; c1_req__ENA = 1'b0;
    mem_resValue__RDY = 1'b0; mem_resAccept__RDY = 1'b0;
    nRST = 1'b1;

    // c0 request, memory answers 3 cycles after grant
    req("t1_grant", 1'b1, 1'b0, 8'b1010_0000, DW'(32'hA5));
    tick();
    chk("t1_wait2", ctl(), 8'b0000_0000);
    tick();
    // Non-owner accept is ignored and the arbiter stays busy
    mem_resValue = DW'(32'h5A); mem_resValue__RDY = 1'b1; mem_resAccept__RDY = 1'b1;
    c1_resAccept__ENA = 1'b1;
    #1;
    chk("t4_nonowner", ctl(), 8'b0000_1100);
    tick();
    chk("t4_still_busy", ctl(), 8'b0000_1100);
    c1_resAccept__ENA = 1'b0;
    serve("t1_serve", 1'b0, DW'(32'h5A));

    // prio now 1: tie goes to c1
    req("t2_tie_c1", 1'b1, 1'b1, 8'b0110_0000, DW'(32'h3C));
    serve("t2_serve_c1", 1'b1, DW'(32'h11));

    // Memory not ready: no grant, prio (0) untouched
    c0_req__ENA = 1'b1; c1_req__ENA = 1'b1; mem_req__RDY = 1'b0;
    #1;
    chk("stall_ctl", ctl(), 8'b0000_0000);
    tick();
    mem_req__RDY = 1'b1;
    req("t2_tie_c0", 1'b1, 1'b1, 8'b1010_0000, DW'(32'hA5));
    serve("t2_serve_c0", 1'b0, DW'(32'h22));

    // Both keep asking: grants alternate c1, c0, c1
    req("t3_a", 1'b1, 1'b1, 8'b0110_0000, DW'(32'h3C));
    serve("t3_a_s", 1'b1, DW'(32'h33));
    req("t3_b", 1'b1, 1'b1, 8'b1010_0000, DW'(32'hA5));
    serve("t3_b_s", 1'b0, DW'(32'h44));
    req("t3_c", 1'b1, 1'b1, 8'b0110_0000, DW'(32'h3C));
    serve("t3_c_s", 1'b1, DW'(32'h55));
    // prio 0, c0 alone; then prio 1, c0 alone (both RDYs high)
    req("c0_alone_p0", 1'b1, 1'b0, 8'b1010_0000, DW'(32'hA5));
    serve("c0_alone_p0_s", 1'b0, DW'(32'h66));
    req("c0_alone_p1", 1'b1, 1'b0, 8'b1110_0000, DW'(32'hA5));
    serve("c0_alone_p1_s", 1'b0, DW'(32'h77));

    // Async reset mid-BUSY with a ready response
    req("t5_grant", 1'b0, 1'b1, 8'b0110_0000, DW'(32'h3C));
    mem_resValue__RDY = 1'b1; mem_resAccept__RDY = 1'b1;
    #1;
    chk("t5_pre_rst", ctl(), 8'b0000_0011);
    #2 nRST = 1'b0;
    #1;
    chk("t5_async_rst", ctl(), 8'b0000_0000);
    tick();
    mem_resValue__RDY = 1'b0; mem_resAccept__RDY = 1'b0; mem_req__RDY = 1'b1;
    nRST = 1'b1;
    // prio back to 0: tie goes to c0
    req("t5_tie", 1'b1, 1'b1, 8'b1010_0000, DW'(32'hA5));
    serve("t5_tie_s", 1'b0, DW'(32'h88));
    req("t5_c1", 1'b0, 1'b1, 8'b0110_0000, DW'(32'h3C));
    serve("t5_c1_s", 1'b1, DW'(32'h99));

`ifdef LPM_ARB_PERF_EN
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    #1;
    chk("perf_rst_c0", c0_grant_count, '0);
    chk("perf_rst_c1", c1_grant_count, '0);
    chk("perf_rst_ct", contend_count, '0);
    req("p_tie0", 1'b1, 1'b1, 8'b1010_0000, DW'(32'hA5));
    serve("p_tie0_s", 1'b0, DW'(32'h1));
    req("p_tie1", 1'b1, 1'b1, 8'b0110_0000, DW'(32'h3C));
    serve("p_tie1_s", 1'b1, DW'(32'h2));
    req("p_c0a", 1'b1, 1'b0, 8'b1010_0000, DW'(32'hA5));
    serve("p_c0a_s", 1'b0, DW'(32'h3));
    for (int i = 0; i < 3; i++) begin
      req("p_c0b", 1'b1, 1'b0, 8'b1110_0000, DW'(32'hA5));
      serve("p_c0b_s", 1'b0, DW'(32'h4));
    end
    req("p_c1a", 1'b0, 1'b1, 8'b0110_0000, DW'(32'h3C));
    serve("p_c1a_s", 1'b1, DW'(32'h5));
    req("p_c1b", 1'b0, 1'b1, 8'b1110_0000, DW'(32'h3C));
    serve("p_c1b_s", 1'b1, DW'(32'h6));
    #1;
    chk("perf_c0", c0_grant_count, DW'(32'd5));
    chk("perf_c1", c1_grant_count, DW'(32'd3));
    chk("perf_ct", contend_count, DW'(32'd2));
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
